// File: rtl/timer_pkg.sv
// Shared definitions for the I/O timer bank.
// Holds the per-channel register offsets, CTRL/STATUS bit positions and a
// helper that packs the STATUS byte returned on reads.
package timer_pkg;

    // Per-channel register offsets (addr[1:0])
    localparam logic [1:0] REG_CNT_LO = 2'd0;
    localparam logic [1:0] REG_CNT_HI = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STAT   = 2'd3;

    // CTRL bit indices
    localparam int EN       = 0;
    localparam int PERIODIC = 1;
    localparam int IE       = 2;
    localparam int TOGGLE   = 3;

    // STATUS bit indices
    localparam int PEND = 0;
    localparam int RUN  = 1;

    // Pack PEND/RUN into the STATUS read byte, upper bits read as zero
    function automatic logic [7:0] stat_byte(input logic pend, input logic run);
        logic [7:0] b;
        b       = 8'd0;
        b[PEND] = pend;
        b[RUN]  = run;
        return b;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One programmable down-counter channel of the I/O timer bank.
// Ports:
//   clk, rst_n  : clock and synchronous active-low reset
//   tick        : count-enable strobe
//   wr_en/rd_en : single-cycle bus write/read pulses already decoded for this channel
//   reg_sel     : register offset within the channel
//   din         : write data
//   rdata       : combinational read data of the selected register
//   out         : timer output (pulse or toggle), registered
//   irq         : PEND & IE, registered
//   pend_ie     : unregistered PEND & IE, lets the top register irq_any in step with irq
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [1:0] reg_sel,
    input  logic [7:0] din,
    output logic [7:0] rdata,
    output logic       out,
    output logic       irq,
    output logic       pend_ie
);

    localparam int HW = CNT_W - 8;

    logic [CNT_W-1:0] reload_r;
    logic [CNT_W-1:0] count_r;
    logic [3:0]       ctrl_r;
    logic             pend_r;
    logic [HW-1:0]    shadow_r;
    logic             latched_r;
    logic             out_r;
    logic             irq_r;

    logic ctrl_wr_s;
    logic stat_wr_s;
    logic en_rise_s;
    logic run_s;
    logic expire_s;

    assign ctrl_wr_s = wr_en & (reg_sel == REG_CTRL);
    assign stat_wr_s = wr_en & (reg_sel == REG_STAT);
    assign en_rise_s = ctrl_wr_s & din[EN] & ~ctrl_r[EN];
    // A same-cycle CTRL write that clears EN suppresses both decrement and expiry
    assign run_s     = ctrl_r[EN] & ~(ctrl_wr_s & ~din[EN]);
    assign expire_s  = tick & run_s & (count_r == CNT_W'(1));

    assign out     = out_r;
    assign irq     = irq_r;
    assign pend_ie = pend_r & ctrl_r[IE];

    // Channel state: reload, ctrl, count, pend, output, irq and readback shadow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reload_r  <= '0;
            count_r   <= '0;
            ctrl_r    <= 4'd0;
            pend_r    <= 1'b0;
            shadow_r  <= '0;
            latched_r <= 1'b0;
            out_r     <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            if (wr_en && reg_sel == REG_CNT_LO) begin
                reload_r[7:0] <= din;
            end
            if (wr_en && reg_sel == REG_CNT_HI) begin
                reload_r[CNT_W-1:8] <= din[HW-1:0];
            end

            // One-shot expiry clears EN even if a CTRL write lands in the same cycle
            if (expire_s && !ctrl_r[PERIODIC]) begin
                ctrl_r <= ctrl_wr_s ? {din[3:1], 1'b0} : {ctrl_r[3:1], 1'b0};
            end else if (ctrl_wr_s) begin
                ctrl_r <= din[3:0];
            end

            // Load on EN rise has priority over any tick in that cycle
            if (en_rise_s) begin
                count_r <= reload_r;
            end else if (expire_s) begin
                count_r <= ctrl_r[PERIODIC] ? reload_r : '0;
            end else if (tick && run_s) begin
                count_r <= count_r - CNT_W'(1);
            end

            // Expiry beats a simultaneous write-1-to-clear
            if (expire_s) begin
                pend_r <= 1'b1;
            end else if (stat_wr_s && din[PEND]) begin
                pend_r <= 1'b0;
            end

            if (expire_s) begin
                out_r <= ctrl_r[TOGGLE] ? ~out_r : 1'b1;
            end else if (!ctrl_r[TOGGLE]) begin
                out_r <= 1'b0;
            end

            irq_r <= pend_r & ctrl_r[IE];

            // Low-byte read snapshots the high byte so a 16-bit read is coherent
            if (rd_en && reg_sel == REG_CNT_LO) begin
                shadow_r  <= count_r[CNT_W-1:8];
                latched_r <= 1'b1;
            end else if (rd_en && reg_sel == REG_CNT_HI) begin
                latched_r <= 1'b0;
            end
        end
    end

    // Read mux for the selected register of this channel
    always_comb begin
        case (reg_sel)
            REG_CNT_LO: rdata = count_r[7:0];
            REG_CNT_HI: rdata = latched_r ? 8'(shadow_r) : 8'(count_r[CNT_W-1:8]);
            REG_CTRL:   rdata = {4'd0, ctrl_r};
            REG_STAT:   rdata = stat_byte(pend_r, ctrl_r[EN]);
            default:    rdata = 8'd0;
        endcase
    end

endmodule

// File: rtl/io_timer_bank.sv
// Multi-channel programmable interval timer on the 8088 I/O bus.
// Ports:
//   clk, rst_n        : clock and synchronous active-low reset
//   tick              : count-enable strobe shared by all channels
//   cs_n, rd_n, wr_n  : active-low bus strobes, held for several clocks
//   addr              : {channel, reg[1:0]}
//   din / dout        : write data / registered read data
//   out, irq          : per-channel timer output and interrupt request
//   irq_any           : OR of all irq lines, registered alongside irq
module io_timer_bank
    import timer_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int AW    = $clog2(NCH) + 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tick,
    input  logic           cs_n,
    input  logic           rd_n,
    input  logic           wr_n,
    input  logic [AW-1:0]  addr,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic [NCH-1:0] out,
    output logic [NCH-1:0] irq,
    output logic           irq_any
);

    localparam int CH_W = (AW > 2) ? AW - 2 : 1;

    logic [CH_W-1:0] ch_idx_s;
    logic            rd_act_s;
    logic            wr_act_s;
    logic            rd_prev_r;
    logic            wr_prev_r;
    logic            rd_pulse_s;
    logic            wr_pulse_s;
    logic [7:0]      ch_rdata_s [NCH];
    logic [NCH-1:0]  pend_ie_s;
    logic [7:0]      rd_mux_s;

    if (AW > 2) begin : g_idx
        assign ch_idx_s = addr[AW-1:2];
    end else begin : g_idx_single
        assign ch_idx_s = 1'b0;
    end

    assign rd_act_s   = ~cs_n & ~rd_n;
    assign wr_act_s   = ~cs_n & ~wr_n;
    // Strobes are level-held, so only the first active cycle acts
    assign rd_pulse_s = rd_act_s & ~rd_prev_r;
    assign wr_pulse_s = wr_act_s & ~wr_prev_r;

    // Previous-cycle strobe levels for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_prev_r <= 1'b0;
            wr_prev_r <= 1'b0;
        end else begin
            rd_prev_r <= rd_act_s;
            wr_prev_r <= wr_act_s;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick),
            .wr_en   (wr_pulse_s & (ch_idx_s == CH_W'(g))),
            .rd_en   (rd_pulse_s & (ch_idx_s == CH_W'(g))),
            .reg_sel (addr[1:0]),
            .din     (din),
            .rdata   (ch_rdata_s[g]),
            .out     (out[g]),
            .irq     (irq[g]),
            .pend_ie (pend_ie_s[g])
        );
    end

    // Channel select for reads; indices with no channel read as zero
    always_comb begin
        rd_mux_s = 8'd0;
        for (int i = 0; i < NCH; i++) begin
            rd_mux_s = rd_mux_s | ((ch_idx_s == CH_W'(i)) ? ch_rdata_s[i] : 8'd0);
        end
    end

    // Registered read data and combined interrupt
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout    <= 8'd0;
            irq_any <= 1'b0;
        end else begin
            if (rd_act_s) begin
                dout <= rd_mux_s;
            end
            irq_any <= |pend_ie_s;
        end
    end

endmodule
